// File: rtl/serial_send.sv
// serial_send: byte FIFO feeding an 8-bit serial transmitter.
// The line idles high. Each frame is a start bit, D0..D7 sent LSB first,
// an optional even-parity bit and one stop bit. Every bit lasts RCONST clocks.
// Optional feature: defining SERIAL_SEND_PARITY_EN adds the PARITY state,
// which sends even parity after D7 and makes the frame 11 bits long.
module serial_send #(
  parameter int RCONST  = 868,
  parameter int FIFO_AW = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_byte,
  input  logic       tx_wr,
  output logic       tx_full,
  output logic       tx_empty,
  output logic       tx_busy,
  output logic       tx
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int BW    = (RCONST > 1) ? $clog2(RCONST) : 1;
  localparam logic [BW-1:0]    BAUD_LAST = BW'(RCONST - 1);
  localparam logic [FIFO_AW:0] LEVEL_MAX = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef SERIAL_SEND_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   level;
  logic               push;
  logic               pop;
  logic [7:0]         head;

  // Transmitter state
  state_t     state, state_next;
  logic [BW-1:0] baud, baud_next;
  logic [2:0] bit_cnt, bit_next;
  logic [7:0] shreg, shreg_next;
  logic       tx_next;
  logic       baud_end;

  // Flags decode the registered level only, so tx_wr never reaches them combinationally.
  assign tx_empty = (level == '0);
  assign tx_full  = (level == LEVEL_MAX);
  assign tx_busy  = (state != IDLE);
  assign head     = mem[rd_ptr];
  assign baud_end = (baud == BAUD_LAST);

  // A full FIFO still accepts a write when the transmitter pops on the same edge.
  assign push = tx_wr && (!tx_full || pop);

  // FIFO pointers and level; simultaneous push and pop leave the level unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      if (push && !pop)      level <= level + (FIFO_AW + 1)'(1);
      else if (pop && !push) level <= level - (FIFO_AW + 1)'(1);
    end
  end

  // FIFO data array; the pointer reset alone makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= tx_byte;
  end

  // Next-state, counter and pop logic; the line level is derived from where the FSM lands.
  always_comb begin
    state_next = state;
    baud_next  = baud;
    bit_next   = bit_cnt;
    shreg_next = shreg;
    pop        = 1'b0;
    tx_next    = 1'b1;

    case (state)
      IDLE: begin
        if (!tx_empty) begin
          pop        = 1'b1;
          shreg_next = head;
          baud_next  = '0;
          state_next = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = DATA;
        end else begin
          baud_next = baud + BW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_next = '0;
          bit_next  = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
`ifdef SERIAL_SEND_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end else begin
          baud_next = baud + BW'(1);
        end
      end
`ifdef SERIAL_SEND_PARITY_EN
      PARITY: begin
        if (baud_end) begin
          baud_next  = '0;
          state_next = STOP;
        end else begin
          baud_next = baud + BW'(1);
        end
      end
`endif
      STOP: begin
        if (baud_end) begin
          baud_next = '0;
          // Back-to-back frames: pop the next byte on the stop-bit boundary.
          if (!tx_empty) begin
            pop        = 1'b1;
            shreg_next = head;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud + BW'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg_next[bit_next];
`ifdef SERIAL_SEND_PARITY_EN
      PARITY:  tx_next = ^shreg_next;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  // Control registers and the registered line output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_next;
      baud    <= baud_next;
      bit_cnt <= bit_next;
      tx      <= tx_next;
    end
  end

  // Shift register holds the byte being sent; loaded on every pop.
  always_ff @(posedge clk) begin
    shreg <= shreg_next;
  end

endmodule

// File: tb/tb_serial_send.sv
// Bench for serial_send: frame-level reference model checked every cycle,
// a line decoder for byte order, and directed literal expectations.
module tb_serial_send;

  localparam int R     = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
`ifdef SERIAL_SEND_PARITY_EN
  localparam int NB = 11;
  localparam logic [10:0] EXP55 = 11'b10010101010;
`else
  localparam int NB = 10;
  localparam logic [10:0] EXP55 = 11'b11010101010;
`endif
  localparam int FL = NB * R;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_byte;
  logic       tx_wr;
  logic       tx_full, tx_empty, tx_busy, tx;

  int n_checks = 0;
  int n_fail   = 0;

  serial_send #(.RCONST(R), .FIFO_AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_byte  (tx_byte),
    .tx_wr    (tx_wr),
    .tx_full  (tx_full),
    .tx_empty (tx_empty),
    .tx_busy  (tx_busy),
    .tx       (tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  mq[$];
  bit          m_act = 1'b0;
  int          m_pos = 0;
  logic [10:0] m_bits = '1;

  function automatic logic [10:0] frame_of(input logic [7:0] b);
`ifdef SERIAL_SEND_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {2'b11, b, 1'b0};
`endif
  endfunction

  task automatic model_step();
    int sz;
    bit popped;
    if (reset) begin
      mq.delete();
      m_act = 1'b0;
      m_pos = 0;
    end else begin
      sz = mq.size();
      popped = 1'b0;
      if (m_act && m_pos < FL - 1) begin
        m_pos++;
      end else if (sz > 0) begin
        m_bits = frame_of(mq.pop_front());
        m_act  = 1'b1;
        m_pos  = 0;
        popped = 1'b1;
      end else begin
        m_act = 1'b0;
      end
      if (tx_wr && (sz < DEPTH || popped)) mq.push_back(tx_byte);
    end
  endtask

  // Model advances on each edge; outputs compared on the following falling edge.
  initial begin
    logic exp_tx;
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      exp_tx = m_act ? m_bits[m_pos / R] : 1'b1;
      check("tx", 32'(tx), 32'(exp_tx));
      check("tx_busy", 32'(tx_busy), 32'(m_act));
      check("tx_empty", 32'(tx_empty), 32'(mq.size() == 0));
      check("tx_full", 32'(tx_full), 32'(mq.size() == DEPTH));
    end
  end

  // ---------------- line decoder ----------------
  logic [7:0] rx_q[$];
  logic       rx_par[$];

  initial begin
    logic [7:0] rb;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        repeat (R / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (R) @(negedge clk);
          rb[k] = tx;
        end
`ifdef SERIAL_SEND_PARITY_EN
        repeat (R) @(negedge clk);
        rx_par.push_back(tx);
`endif
        repeat (R) @(negedge clk);
        rx_q.push_back(rb);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic w, input logic [7:0] b, input logic r);
    tx_wr   = w;
    tx_byte = b;
    reset   = r;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0);
  endtask

  logic       samp   [0:2*FL];
  logic       bsamp  [0:2*FL];
  logic       esamp  [0:2*FL];

  initial begin
    logic [10:0] got;
    int          cnt;

    reset = 1'b1; tx_wr = 1'b0; tx_byte = 8'h00;
    repeat (3) drive(1'b0, 8'h00, 1'b1);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_empty", 32'(tx_empty), 32'd1);
    check("rst_full", 32'(tx_full), 32'd0);
    idle(3);

    // Single 0x55 frame
    rx_q.delete();
    drive(1'b1, 8'h55, 1'b0);
    check("f55_tx_at_write", 32'(tx), 32'd1);
    check("f55_empty_at_write", 32'(tx_empty), 32'd0);
    for (int s = 0; s <= FL; s++) begin
      drive(1'b0, 8'h00, 1'b0);
      samp[s] = tx;
      bsamp[s] = tx_busy;
    end
    got = '1;
    for (int k = 0; k < NB; k++) got[k] = samp[k * R + 1];
    cnt = 0;
    for (int s = 0; s <= FL; s++) if (bsamp[s]) cnt++;
    check("f55_first_low", 32'(samp[0]), 32'd0);
    check("f55_bits", 32'(got), 32'(EXP55));
    check("f55_busy_cycles", 32'(cnt), 32'(FL));
    check("f55_end_tx", 32'(samp[FL]), 32'd1);
    check("f55_rx_count", 32'(rx_q.size()), 32'd1);
    check("f55_rx_byte", 32'((rx_q.size() > 0) ? rx_q[0] : 8'h00), 32'h55);
    idle(4);

    // Back-to-back 0x01, 0x80
    rx_q.delete();
    drive(1'b1, 8'h01, 1'b0);
    drive(1'b1, 8'h80, 1'b0);
    samp[0] = tx; bsamp[0] = tx_busy; esamp[0] = tx_empty;
    for (int s = 1; s <= 2 * FL; s++) begin
      drive(1'b0, 8'h00, 1'b0);
      samp[s] = tx; bsamp[s] = tx_busy; esamp[s] = tx_empty;
    end
    cnt = 0;
    for (int s = 0; s <= 2 * FL; s++) if (bsamp[s]) cnt++;
    check("b2b_first_start", 32'(samp[0]), 32'd0);
    check("b2b_stop_bit", 32'(samp[FL - 1]), 32'd1);
    check("b2b_second_start", 32'(samp[FL]), 32'd0);
    check("b2b_empty_after_pop2", 32'(esamp[FL]), 32'd1);
    check("b2b_busy_cycles", 32'(cnt), 32'(2 * FL));
    idle(4);
    check("b2b_rx_count", 32'(rx_q.size()), 32'd2);
    check("b2b_rx0", 32'((rx_q.size() > 0) ? rx_q[0] : 8'h00), 32'h01);
    check("b2b_rx1", 32'((rx_q.size() > 1) ? rx_q[1] : 8'h00), 32'h80);

    // FIFO fill with overflow
    rx_q.delete();
    for (int i = 0; i < 4; i++) drive(1'b1, 8'hA0 + 8'(i), 1'b0);
    check("fill_not_full_4", 32'(tx_full), 32'd0);
    drive(1'b1, 8'hA4, 1'b0);
    check("fill_full_5", 32'(tx_full), 32'd1);
    drive(1'b1, 8'hA5, 1'b0);
    check("fill_full_6", 32'(tx_full), 32'd1);
    idle(5 * FL + 10);
    check("fill_rx_count", 32'(rx_q.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      check("fill_rx_order", 32'((i < rx_q.size()) ? rx_q[i] : 8'h00), 32'(8'hA0 + 8'(i)));

    // Reset mid-frame with bytes queued (and a write in the reset cycle)
    drive(1'b1, 8'hFF, 1'b0);
    drive(1'b1, 8'h11, 1'b0);
    drive(1'b1, 8'h22, 1'b0);
    idle(13);
    drive(1'b1, 8'h33, 1'b1);
    check("rst_mid_tx", 32'(tx), 32'd1);
    check("rst_mid_busy", 32'(tx_busy), 32'd0);
    check("rst_mid_empty", 32'(tx_empty), 32'd1);
    cnt = 0;
    for (int s = 0; s < 3 * FL; s++) begin
      drive(1'b0, 8'h00, 1'b0);
      if (tx_busy) cnt++;
    end
    check("rst_mid_no_frame", 32'(cnt), 32'd0);
    check("rst_mid_still_empty", 32'(tx_empty), 32'd1);

`ifdef SERIAL_SEND_PARITY_EN
    // Parity values
    rx_q.delete();
    rx_par.delete();
    drive(1'b1, 8'h07, 1'b0);
    drive(1'b1, 8'h03, 1'b0);
    idle(2 * FL + 10);
    check("par_07", 32'((rx_par.size() > 0) ? rx_par[0] : 1'b0), 32'd1);
    check("par_03", 32'((rx_par.size() > 1) ? rx_par[1] : 1'b1), 32'd0);
    check("par_rx0", 32'((rx_q.size() > 0) ? rx_q[0] : 8'h00), 32'h07);
    check("par_rx1", 32'((rx_q.size() > 1) ? rx_q[1] : 8'h00), 32'h03);
`endif

    // Randomised traffic with bursts and occasional resets
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) < (((i / 500) % 2 == 1) ? 30 : 3)) ? 1'b1 : 1'b0,
            8'($urandom_range(0, 255)),
            ($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0);
    end
    idle(6 * FL);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_send.md
SERIAL_SEND -- requirements
Module: serial_send

Interface
REQ-001 Parameter RCONST, default 868, clk cycles per serial bit (115200 baud at 100 MHz); legal range 2..65535.
REQ-002 Parameter FIFO_AW, default 4, FIFO address width; depth is 2^FIFO_AW bytes.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tx_byte  input  8  byte to send; sampled when tx_wr=1.
REQ-006 tx_wr  input  1  one-cycle write strobe; pushes tx_byte into the FIFO.
REQ-007 tx_full  output  1  FIFO holds 2^FIFO_AW bytes.
REQ-008 tx_empty  output  1  FIFO holds 0 bytes.
REQ-009 tx_busy  output  1  high while a frame is on the line (state not IDLE).
REQ-010 tx  output  1  serial line, idle high; drives top-level serial_tx.

Function
REQ-011 Frame format: start bit 0, D0..D7 LSB first, optional parity (REQ-030), one stop bit 1. Each bit lasts exactly RCONST clk cycles.
REQ-012 The FIFO is synchronous and first-in first-out. A write with tx_full=1 and no same-cycle pop is dropped. FIFO contents are unchanged.
REQ-013 Simultaneous write and pop when full: the write is accepted and the level stays at full.
REQ-014 Simultaneous write and pop at level 1: the level stays at 1 and the new byte becomes the head.
REQ-015 tx_full and tx_empty reflect the level registered after each edge, with no combinational path from tx_wr.
REQ-016 State machine: IDLE, START, DATA, PARITY (present only with REQ-030), STOP.
REQ-017 In IDLE with tx_empty=0: pop the head byte into the shift register and enter START on the same edge.
REQ-018 START, DATA and PARITY each last RCONST cycles per bit. A 3-bit counter selects D0..D7 in DATA.
REQ-019 STOP lasts RCONST cycles. At its end, go to START directly if the FIFO is non-empty, popping on that edge with no idle gap. Otherwise go to IDLE.
REQ-020 Latency: a byte written at edge N into an empty FIFO while in IDLE causes the pop at edge N+1. tx is low after edge N+1.
REQ-021 The bit counter and baud counter wrap cleanly. The baud counter counts 0..RCONST-1 and reloads to 0 at each bit boundary.
REQ-022 tx is a registered output with no glitches between bits.

Reset
REQ-023 While reset=1 at an edge, the following values apply after that edge: tx=1, tx_busy=0, tx_empty=1, tx_full=0, state=IDLE, all counters 0, FIFO pointers 0.
REQ-024 Reset mid-frame aborts the frame. tx is high after the reset edge, and queued bytes are discarded.
REQ-025 A tx_wr asserted in the same cycle as reset is ignored.

Configuration
REQ-030 Macro SERIAL_SEND_PARITY_EN controls parity.
- Defined: the PARITY state is inserted after D7 and sends even parity (XOR of D0..D7). The frame is 11 bits.
- Undefined: the PARITY state and its logic are absent. The frame is 10 bits and goes DATA to STOP directly.

Verification
REQ-040 RCONST=4, no parity, write 0x55 once:
- tx is low one edge after the write.
- Sequence per 4-cycle bit: 0,1,0,1,0,1,0,1,0,1.
- tx_busy is high for 40 cycles, then tx returns to 1 and tx_busy to 0.
REQ-041 RCONST=4, write 0x01 and 0x80 in consecutive cycles:
- Two 40-cycle frames follow back-to-back with no idle cycle between the stop bit and the second start bit.
- tx_empty=1 after the second pop.
REQ-042 FIFO_AW=2, line stalled by the first frame, write 6 bytes 0xA0..0xA5:
- tx_full=1 after the 5th write (1 in shift register plus 4 in FIFO).
- The 6th write is dropped.
- Output order is 0xA0..0xA4 only.
REQ-043 RCONST=4, reset asserted one cycle at cycle 15 of a 0xFF frame with 2 bytes queued:
- tx=1, tx_busy=0 and tx_empty=1 next cycle.
- No further frame follows without a new write.
REQ-044 SERIAL_SEND_PARITY_EN defined, RCONST=4:
- Byte 0x07 gives parity bit 1.
- Byte 0x03 gives parity bit 0.
- Each frame is 44 cycles.
